// File: rtl/csc_rgb2ycc.sv
// Programmable RGB -> YCbCr converter: signed 3x3 matrix + offsets, shadow/active coefficient banks.
// Optional 4:2:2 chroma pre-averaging when CSC_CHROMA_422_EN is defined.
module csc_rgb2ycc #(
   parameter int DW = 8,
   parameter int FW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0][DW-1:0]   rgb,
   input  logic                 rgb_valid,
   output logic                 rgb_hold,
   input  logic                 frame_valid_in,
   input  logic                 line_valid_in,
   output logic [2:0][DW-1:0]   yuv,
   output logic                 yuv_valid,
   input  logic                 yuv_hold,
   output logic                 frame_valid_out,
   output logic                 line_valid_out,
   input  logic                 coef_wr,
   input  logic [3:0]           coef_addr,
   input  logic signed [FW+1:0] coef_wdata,
   input  logic                 coef_commit,
   output logic                 coef_busy
);

   localparam int CW = FW + 2;
   localparam int OW = DW + 1;
   localparam int PW = DW + FW + 3;
   localparam int SW = DW + FW + 5;
   localparam int RW = DW + 5;
   localparam logic signed [SW-1:0] RND = SW'(1) <<< (FW - 1);

   function automatic logic signed [CW-1:0] mat_rst(input int unsigned i);
      int base;
      case (i)
         0:       base = 77;
         1:       base = 150;
         2:       base = 29;
         3:       base = -43;
         4:       base = -85;
         5:       base = 128;
         6:       base = 128;
         7:       base = -107;
         8:       base = -21;
         default: base = 0;
      endcase
      return CW'(base <<< (FW - 8));
   endfunction

   function automatic logic [DW-1:0] clamp(input logic signed [RW-1:0] x);
      logic [DW-1:0] r;
      if (x[RW-1])
         r = '0;
      else if (|x[RW-2:DW])
         r = '1;
      else
         r = x[DW-1:0];
      return r;
   endfunction

   localparam logic signed [CW-1:0] MAT_RST [9] = '{mat_rst(0), mat_rst(1), mat_rst(2),
                                                    mat_rst(3), mat_rst(4), mat_rst(5),
                                                    mat_rst(6), mat_rst(7), mat_rst(8)};
   localparam logic signed [OW-1:0] OFF_RST [3] = '{OW'(0), OW'(1) << (DW - 1), OW'(1) << (DW - 1)};

   typedef enum logic {IDLE, ARMED} cstate_t;
   cstate_t state, state_nxt;
   logic    commit_go;

   logic signed [CW-1:0] sh_m [9];
   logic signed [CW-1:0] ac_m [9];
   logic signed [CW-1:0] sh_m_nxt [9];
   logic signed [OW-1:0] sh_o [3];
   logic signed [OW-1:0] ac_o [3];
   logic signed [OW-1:0] sh_o_nxt [3];
   logic [1:0]           off_idx;

   logic v0, v1, v2, fv0, fv1, fv2, lv0, lv1, lv2;
   logic signed [PW-1:0] prod_c [9];
   logic signed [PW-1:0] prod [9];
   logic signed [SW-1:0] acc [3];
   logic signed [RW-1:0] row_c [3];
   logic signed [RW-1:0] row [3];
   logic [DW-1:0]        cl [3];
   logic [1:0][DW-1:0]   ch;

   assign rgb_hold  = yuv_hold;
   assign coef_busy = (state == ARMED);
   assign off_idx   = 2'(coef_addr - 4'd9);

   // Writes landing in the transfer cycle itself are merged into what gets copied.
   always_comb begin
      sh_m_nxt = sh_m;
      sh_o_nxt = sh_o;
      if (coef_wr) begin
         if (coef_addr < 4'd9)
            sh_m_nxt[coef_addr] = coef_wdata;
         else if (coef_addr < 4'd12)
            sh_o_nxt[off_idx] = OW'(coef_wdata);
      end
   end

   always_comb begin
      state_nxt = state;
      commit_go = 1'b0;
      case (state)
         IDLE:  if (coef_commit) state_nxt = ARMED;
         ARMED: if (!frame_valid_in && !v0 && !v1 && !v2) begin
            commit_go = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sh_m  <= MAT_RST;
         ac_m  <= MAT_RST;
         sh_o  <= OFF_RST;
         ac_o  <= OFF_RST;
      end else begin
         state <= state_nxt;
         sh_m  <= sh_m_nxt;
         sh_o  <= sh_o_nxt;
         if (commit_go) begin
            ac_m <= sh_m_nxt;
            ac_o <= sh_o_nxt;
         end
      end
   end

   for (genvar k = 0; k < 9; k++) begin : g_prod
      assign prod_c[k] = PW'($signed({1'b0, rgb[k % 3]})) * PW'(ac_m[k]);
   end

   // Offsets are read live at S1; commits only happen with the pipeline empty.
   for (genvar r = 0; r < 3; r++) begin : g_row
      assign acc[r]   = SW'(prod[3*r]) + SW'(prod[3*r+1]) + SW'(prod[3*r+2])
                      + (SW'(ac_o[r]) <<< FW) + RND;
      assign row_c[r] = RW'(acc[r] >>> FW);
      assign cl[r]    = clamp(row[r]);
   end

`ifdef CSC_CHROMA_422_EN
   logic          par, line_start, pix_odd;
   logic [DW-1:0] prev_cb, prev_cr;

   function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b} + OW'(1);
      return s[DW:1];
   endfunction

   assign line_start = lv1 & ~lv2;
   assign pix_odd    = par & ~line_start;
   assign ch[0]      = pix_odd ? avg2(prev_cb, cl[1]) : cl[1];
   assign ch[1]      = pix_odd ? avg2(prev_cr, cl[2]) : cl[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par     <= 1'b0;
         prev_cb <= '0;
         prev_cr <= '0;
      end else if (!yuv_hold) begin
         if (line_start)
            par <= v1;
         else if (v1)
            par <= ~par;
         if (v1) begin
            prev_cb <= cl[1];
            prev_cr <= cl[2];
         end
      end
   end
`else
   assign ch[0] = cl[1];
   assign ch[1] = cl[2];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v0   <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         fv0  <= 1'b0;
         fv1  <= 1'b0;
         fv2  <= 1'b0;
         lv0  <= 1'b0;
         lv1  <= 1'b0;
         lv2  <= 1'b0;
         prod <= '{default: '0};
         row  <= '{default: '0};
         yuv  <= '0;
      end else if (!yuv_hold) begin
         v0  <= rgb_valid;
         v1  <= v0;
         v2  <= v1;
         fv0 <= frame_valid_in;
         fv1 <= fv0;
         fv2 <= fv1;
         lv0 <= line_valid_in;
         lv1 <= lv0;
         lv2 <= lv1;
         if (rgb_valid) prod <= prod_c;
         if (v0)        row  <= row_c;
         if (v1)        yuv  <= {ch[1], ch[0], cl[0]};
      end
   end

   assign yuv_valid       = v2;
   assign frame_valid_out = fv2;
   assign line_valid_out  = lv2;

endmodule

// File: doc/csc_rgb2ycc.md
# csc_rgb2ycc

Parametrised, run-time programmable RGB-to-YCbCr colour-space converter for the JPEG encoder image pipeline. It replaces the fixed BT.601 converter and applies a full signed 3x3 matrix plus per-channel offsets. It has a shadowed coefficient register bank that commits only between frames, and an optional 4:2:2 horizontal chroma pre-averaging stage. It sits between the debayer/RGB source and the JPEG subsampling/MCU buffer, and uses the same valid/hold stream handshake and frame/line valid sideband.

## Interface
Parameters:
- DW, 8: component width in bits, input and output.
- FW, 8: coefficient fractional bits. Must be at least 8.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rgb  in  3x DW  unsigned pixel: [0]=R, [1]=G, [2]=B.
- rgb_valid  in  1  input pixel valid.
- rgb_hold  out  1  backpressure to the source; equals yuv_hold combinationally.
- frame_valid_in, line_valid_in  in  1 each  sideband, pipelined alongside the data.
- yuv  out  3x DW  [0]=Y, [1]=Cb, [2]=Cr.
- yuv_valid  out  1  output pixel valid.
- yuv_hold  in  1  downstream stall.
- frame_valid_out, line_valid_out  out  1 each  delayed sideband.
- coef_wr  in  1  write strobe into the shadow bank.
- coef_addr  in  4  register address. 0-8 select matrix element row*3+col (rows Y, Cb, Cr; columns R, G, B). 9-11 select offsets Y, Cb, Cr. Addresses 12-15 are ignored.
- coef_wdata  in  FW+2  signed write data; offsets use the low DW+1 bits, signed.
- coef_commit  in  1  request to transfer the shadow bank to the active bank.
- coef_busy  out  1  a commit is pending.

## Operation
- Reset values at FW=8, applied to both banks:
  - Y row: 77, 150, 29.
  - Cb row: -43, -85, 128.
  - Cr row: 128, -107, -21.
  - Offsets: 0, 2^(DW-1), 2^(DW-1).
- For FW>8, matrix reset values are shifted left by FW-8.
- Pipeline (every stage enables on !yuv_hold; data registers additionally gate on their stage valid):
  - S0: register the 9 signed products rgb*coef, each DW+FW+3 bits. The active bank is sampled here.
  - S1: row sums with 2 guard bits. Add (offset<<FW) + (1<<(FW-1)), then arithmetic shift right by FW.
  - S2: clamp to [0, 2^DW-1] and register to yuv.
- Sideband: valid, frame_valid and line_valid move through three matching registers, stalled by yuv_hold.
- Commit state machine, two states:
  - IDLE: coef_commit moves to ARMED.
  - ARMED: when frame_valid_in=0 and the pipeline has no valid pixel in flight, copy shadow to active in one cycle and return to IDLE.
  - coef_busy = (state==ARMED).
- A commit issued while already ARMED is absorbed, with no effect.
- A coef_wr in the same cycle as coef_commit, or any write while ARMED, is included in the eventual transfer.
- The active bank never changes while frame_valid_in=1, so one frame always uses one matrix.

## Timing
- Latency: 3 cycles from an accepted rgb_valid to yuv_valid when yuv_hold=0. Throughput: 1 pixel per cycle.
- yuv_hold=1 freezes all pipeline and sideband registers. Outputs hold their values and nothing is lost or duplicated.
- rgb_hold equals yuv_hold in the same cycle, with no register between them.
- Reset (asynchronous, any time, including mid-frame or mid-commit):
  - yuv_valid, frame_valid_out, line_valid_out = 0.
  - yuv = 0.
  - coef_busy = 0, state = IDLE.
  - Both banks return to their reset values.
  - Data in flight is discarded.
- A shadow write becomes visible at the output no earlier than 4 cycles after the commit transfer cycle.

## Configuration
- CSC_CHROMA_422_EN defined:
  - S2 keeps a pixel-parity bit, cleared on each line_valid rising edge at S2 and toggled per valid output pixel.
  - Odd-parity pixels output Cb and Cr as (c_prev + c_cur + 1) >> 1 of the clamped even/odd pair.
  - Even-parity pixels pass their own chroma.
  - Y is untouched and latency is unchanged.
  - An odd-length line ends on an even pixel, which keeps its own chroma.
- CSC_CHROMA_422_EN undefined: no parity logic; chroma passes straight from the clamp.

## Test plan
- Reset defaults at DW=8: white (255,255,255) -> (255,128,128) 3 cycles later; black (0,0,0) -> (0,128,128); red (255,0,0) -> (77,85,255), which exercises the Cr clamp at 256.
- Stall: stream 8 distinct pixels with yuv_hold=1 for 5 cycles mid-stream -> exactly 8 outputs, in order, unchanged during the hold, with rgb_hold mirroring yuv_hold.
- Commit deferral: write Y row = 256,0,0, then pulse coef_commit while frame_valid_in=1 -> coef_busy=1 and red still gives Y=77 until the frame ends; the next frame gives Y=255 and coef_busy=0.
- Write/commit race: coef_wr to address 10 (Cb offset = 0) in the same cycle as coef_commit while idle -> after the transfer, grey (128,128,128) gives Cb=0.
- Asynchronous reset mid-frame with 3 pixels in flight -> yuv_valid=0 immediately, no stale outputs afterwards, coef_busy=0.
- With CSC_CHROMA_422_EN: a line of red then white -> second output Cb=(85+128+1)>>1=107 and Cr=(255+128+1)>>1=192; the first output keeps Cb=85, Cr=255.
